// File: rtl/lvg_sequencer.sv
// Instruction sequencer for the lvg systolic core: fetches {weight_addr, opcode}
// words, drives weight-memory strobes and the lvg opcode, and sequences compute latency.
module lvg_sequencer #(
  parameter int IADDR_W = 8,
  parameter int WADDR_W = 8,
  parameter int OP_W    = 8,
  parameter int MM_LAT  = 13,
  parameter int ACT_LAT = 14,
  parameter int CNT_W   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stall,
  output logic [IADDR_W-1:0]        instr_addr,
  input  logic [WADDR_W+OP_W-1:0]   instr_data,
  output logic [OP_W-1:0]           op,
  output logic                      op_valid,
  output logic [WADDR_W-1:0]        weight_addr,
  output logic                      read_weight,
  output logic                      write_weight,
  output logic                      busy,
  output logic                      halted,
  output logic                      illegal
);

  localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LDA   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LDB   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_READ  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MM0   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MM1   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ACT0  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_ACT1  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_JMP   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SETL  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_DJNZ  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_HALT  = '1;

  localparam logic [CNT_W-1:0] MM_LAST  = CNT_W'(MM_LAT - 1);
  localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'(ACT_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t               state_q, state_d;
  logic [IADDR_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]     lat_q, lat_d;
  logic [WADDR_W-1:0]   loop_q, loop_d;
  logic [OP_W-1:0]      op_q, op_d;
  logic [WADDR_W-1:0]   wa_q, wa_d;
  logic                 ill_q, ill_d;
  // Strobes decided in DECODE wait here until the first unstalled cycle.
  logic                 vld_p1, vld_d;
  logic                 rd_p1, rd_d;
  logic                 wr_p1, wr_d;
  logic [OP_W-1:0]      dec_op;
  logic [WADDR_W-1:0]   dec_wa;
  logic [IADDR_W-1:0]   tgt;

  function automatic logic is_known(input logic [OP_W-1:0] o);
    case (o)
      OP_NOP, OP_LDA, OP_LDB, OP_READ, OP_STORE, OP_MM0, OP_MM1,
      OP_ACT0, OP_ACT1, OP_JMP, OP_SETL, OP_DJNZ, OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign dec_op = instr_data[OP_W-1:0];
  assign dec_wa = instr_data[OP_W +: WADDR_W];
  assign tgt    = IADDR_W'(wa_q);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    lat_d   = lat_q;
    loop_d  = loop_q;
    op_d    = op_q;
    wa_d    = wa_q;
    ill_d   = ill_q;
    vld_d   = vld_p1 & stall;
    rd_d    = rd_p1 & stall;
    wr_d    = wr_p1 & stall;
    if (!stall) begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc_d    = '0;
            ill_d   = 1'b0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: state_d = S_DECODE;
        S_DECODE: begin
          op_d    = dec_op;
          wa_d    = dec_wa;
          vld_d   = 1'b1;
          rd_d    = (dec_op == OP_LDA) || (dec_op == OP_LDB) || (dec_op == OP_READ);
          wr_d    = (dec_op == OP_STORE);
          lat_d   = '0;
          state_d = S_EXEC;
          if (!is_known(dec_op)) ill_d = 1'b1;
        end
        S_EXEC: begin
          state_d = S_FETCH;
          pc_d    = pc_q + IADDR_W'(1);
          case (op_q)
            OP_MM0, OP_MM1: begin
              if (lat_q != MM_LAST) begin
                state_d = S_EXEC;
                pc_d    = pc_q;
                lat_d   = lat_q + CNT_W'(1);
              end
            end
            OP_ACT0, OP_ACT1: begin
              if (lat_q != ACT_LAST) begin
                state_d = S_EXEC;
                pc_d    = pc_q;
                lat_d   = lat_q + CNT_W'(1);
              end
            end
            OP_JMP:  pc_d = tgt;
            OP_SETL: loop_d = wa_q;
            OP_DJNZ: begin
              if (loop_q != '0) begin
                loop_d = loop_q - WADDR_W'(1);
                pc_d   = tgt;
              end
            end
            OP_HALT: begin
              state_d = S_HALT;
              pc_d    = pc_q;
            end
            default: ;
          endcase
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      lat_q   <= '0;
      loop_q  <= '0;
      op_q    <= '0;
      wa_q    <= '0;
      ill_q   <= 1'b0;
      vld_p1  <= 1'b0;
      rd_p1   <= 1'b0;
      wr_p1   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lat_q   <= lat_d;
      loop_q  <= loop_d;
      op_q    <= op_d;
      wa_q    <= wa_d;
      ill_q   <= ill_d;
      vld_p1  <= vld_d;
      rd_p1   <= rd_d;
      wr_p1   <= wr_d;
    end
  end

  assign instr_addr   = pc_q;
  assign op           = op_q;
  assign weight_addr  = wa_q;
  assign op_valid     = vld_p1 & ~stall;
  assign read_weight  = rd_p1 & ~stall;
  assign write_weight = wr_p1 & ~stall;
  assign busy         = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
  assign halted       = (state_q == S_HALT);
  assign illegal      = ill_q;

endmodule

// File: tb/tb_lvg_sequencer.sv
// Directed bench for lvg_sequencer: single-instruction vector table plus
// hand-written multi-cycle programs (timing, loops, wrap, stall, reset).
module tb_lvg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [7:0]  instr_addr;
  logic [15:0] instr_data;
  logic [7:0]  op;
  logic        op_valid;
  logic [7:0]  weight_addr;
  logic        read_weight;
  logic        write_weight;
  logic        busy;
  logic        halted;
  logic        illegal;

  logic [15:0] mem [0:255];

  int total = 0;
  int bad = 0;

  int n_busy, n_rd, n_wr, n_ov, rd_cyc, wr_cyc, ov_cyc, trk_cyc, halt_cyc, both;
  int rd_wa, wr_wa;
  int op_seen [0:255];

  typedef struct {
    logic [7:0] wa;
    logic [7:0] opc;
    int         busy;
    int         rd;
    int         wr;
    int         ill;
    int         ov;
    int         pc;
  } vec_t;

  vec_t vt [14];

  lvg_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stall        (stall),
    .instr_addr   (instr_addr),
    .instr_data   (instr_data),
    .op           (op),
    .op_valid     (op_valid),
    .weight_addr  (weight_addr),
    .read_weight  (read_weight),
    .write_weight (write_weight),
    .busy         (busy),
    .halted       (halted),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) instr_data <= mem[instr_addr];

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h00FF;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Starts the program and records strobe activity per cycle; cycle 0 is the first FETCH.
  task automatic run_prog(input int budget, input int sa0, input int sb0,
                          input int sa1, input int sb1, input int trk);
    int cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_busy = 0; n_rd = 0; n_wr = 0; n_ov = 0; both = 0;
    rd_cyc = -1; wr_cyc = -1; ov_cyc = -1; trk_cyc = -1; halt_cyc = -1;
    rd_wa = -1; wr_wa = -1;
    for (int i = 0; i < 256; i++) op_seen[i] = 0;
    cyc = 0;
    while (!halted && cyc < budget) begin
      stall = ((cyc >= sa0) && (cyc <= sb0)) || ((cyc >= sa1) && (cyc <= sb1));
      #1;
      if (busy) n_busy++;
      if (op_valid) begin
        n_ov++;
        op_seen[op]++;
        if (ov_cyc < 0) ov_cyc = cyc;
      end
      if (read_weight) begin
        n_rd++;
        rd_cyc = cyc;
        rd_wa = int'(weight_addr);
      end
      if (write_weight) begin
        n_wr++;
        wr_cyc = cyc;
        wr_wa = int'(weight_addr);
      end
      if (read_weight && write_weight) both++;
      if ((cyc > 0) && (trk_cyc < 0) && (int'(instr_addr) == trk)) trk_cyc = cyc;
      @(posedge clk);
      #1;
      cyc++;
    end
    stall = 1'b0;
    if (halted) halt_cyc = cyc;
  endtask

  initial begin
    vt[0]  = '{8'h00, 8'h00,  6, 0, 0, 0, 2, 8'h01};
    vt[1]  = '{8'h12, 8'h01,  6, 1, 0, 0, 2, 8'h01};
    vt[2]  = '{8'h55, 8'h02,  6, 1, 0, 0, 2, 8'h01};
    vt[3]  = '{8'h77, 8'h03,  6, 1, 0, 0, 2, 8'h01};
    vt[4]  = '{8'h34, 8'h04,  6, 0, 1, 0, 2, 8'h01};
    vt[5]  = '{8'h00, 8'h05, 18, 0, 0, 0, 2, 8'h01};
    vt[6]  = '{8'h00, 8'h06, 18, 0, 0, 0, 2, 8'h01};
    vt[7]  = '{8'h00, 8'h07, 19, 0, 0, 0, 2, 8'h01};
    vt[8]  = '{8'h00, 8'h08, 19, 0, 0, 0, 2, 8'h01};
    vt[9]  = '{8'h20, 8'h09,  6, 0, 0, 0, 2, 8'h20};
    vt[10] = '{8'h05, 8'h0A,  6, 0, 0, 0, 2, 8'h01};
    vt[11] = '{8'h40, 8'h0B,  6, 0, 0, 0, 2, 8'h01};
    vt[12] = '{8'h00, 8'h42,  6, 0, 0, 1, 2, 8'h01};
    vt[13] = '{8'h00, 8'hFF,  3, 0, 0, 0, 1, 8'h00};

    clear_mem();
    do_reset();
    chk("rst_busy", int'(busy), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_addr", int'(instr_addr), 0);
    chk("rst_strobes", int'({op_valid, read_weight, write_weight, illegal}), 0);
    chk("rst_op_wa", int'({op, weight_addr}), 0);

    for (int v = 0; v < 14; v++) begin
      clear_mem();
      mem[0] = {vt[v].wa, vt[v].opc};
      do_reset();
      run_prog(100, -1, -1, -1, -1, 1);
      chk($sformatf("v%0d_halted", v), int'(halt_cyc >= 0), 1);
      chk($sformatf("v%0d_busy", v), n_busy, vt[v].busy);
      chk($sformatf("v%0d_rd", v), n_rd, vt[v].rd);
      chk($sformatf("v%0d_wr", v), n_wr, vt[v].wr);
      chk($sformatf("v%0d_ill", v), int'(illegal), vt[v].ill);
      chk($sformatf("v%0d_ov", v), n_ov, vt[v].ov);
      chk($sformatf("v%0d_pc", v), int'(instr_addr), vt[v].pc);
      if (vt[v].rd != 0) chk($sformatf("v%0d_rd_wa", v), rd_wa, int'(vt[v].wa));
      if (vt[v].wr != 0) chk($sformatf("v%0d_wr_wa", v), wr_wa, int'(vt[v].wa));
    end

    // Load / store / halt, cycle exact
    clear_mem();
    mem[0] = 16'h1201;
    mem[1] = 16'h3404;
    do_reset();
    run_prog(50, -1, -1, -1, -1, 1);
    chk("t1_rd_cyc", rd_cyc, 2);
    chk("t1_rd_wa", rd_wa, 8'h12);
    chk("t1_wr_cyc", wr_cyc, 5);
    chk("t1_wr_wa", wr_wa, 8'h34);
    chk("t1_halt_cyc", halt_cyc, 9);
    chk("t1_both", both, 0);

    // Compute latency: next FETCH relative to EXEC entry
    clear_mem();
    mem[0] = 16'h0005;
    do_reset();
    run_prog(60, -1, -1, -1, -1, 1);
    chk("t2_mm_lat", trk_cyc - ov_cyc, 13);
    chk("t2_mm_ov", op_seen[5], 1);
    clear_mem();
    mem[0] = 16'h0007;
    do_reset();
    run_prog(60, -1, -1, -1, -1, 1);
    chk("t2_act_lat", trk_cyc - ov_cyc, 14);
    chk("t2_act_ov", op_seen[7], 1);

    // Hardware loop
    clear_mem();
    mem[0] = 16'h030A;
    mem[1] = 16'h0000;
    mem[2] = 16'h010B;
    do_reset();
    run_prog(100, -1, -1, -1, -1, 99);
    chk("t3_nops", op_seen[0], 4);
    chk("t3_djnz", op_seen[11], 4);
    chk("t3_halted", int'(halt_cyc >= 0), 1);
    chk("t3_pc", int'(instr_addr), 3);
    // loop_cnt left at zero: a lone DJNZ must fall through
    clear_mem();
    mem[0] = 16'h300B;
    run_prog(30, -1, -1, -1, -1, 99);
    chk("t3_cnt_zero_pc", int'(instr_addr), 1);

    // JMP to last address and PC wrap
    clear_mem();
    mem[0] = 16'hFF09;
    mem[255] = 16'h0000;
    do_reset();
    begin
      int seq [4];
      int ns;
      logic [7:0] last;
      ns = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      last = instr_addr;
      seq[0] = int'(instr_addr);
      ns = 1;
      for (int c = 0; c < 12 && ns < 4; c++) begin
        tick();
        if (instr_addr != last) begin
          seq[ns] = int'(instr_addr);
          ns++;
          last = instr_addr;
        end
      end
      chk("t4_n", ns, 4);
      chk("t4_a0", seq[0], 8'h00);
      chk("t4_a1", seq[1], 8'hFF);
      chk("t4_a2", seq[2], 8'h00);
      chk("t4_a3", seq[3], 8'hFF);
    end

    // Stall during READ EXEC and during opcode 6 wait
    clear_mem();
    mem[0] = 16'h6603;
    mem[1] = 16'h0006;
    do_reset();
    run_prog(80, 2, 6, 13, 17, 2);
    chk("t5_rd_n", n_rd, 1);
    chk("t5_rd_cyc", rd_cyc, 7);
    chk("t5_rd_wa", rd_wa, 8'h66);
    chk("t5_ov_n", n_ov, 3);
    chk("t5_mm_exec", trk_cyc - 10, 18);
    chk("t5_halt_cyc", halt_cyc, 31);

    // Illegal opcode, then restart clears it
    clear_mem();
    mem[0] = 16'h0042;
    do_reset();
    run_prog(50, -1, -1, -1, -1, 1);
    chk("t6_ill", int'(illegal), 1);
    chk("t6_ill_halt", int'(halt_cyc >= 0), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_restart_ill", int'(illegal), 0);
    chk("t6_restart_pc", int'(instr_addr), 0);
    chk("t6_restart_busy", int'({busy, halted}), 2);

    // Reset in the middle of a matmul wait
    clear_mem();
    mem[0] = 16'h9905;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("t6_pre_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_busy", int'({busy, halted}), 0);
    chk("t6_rst_strobes", int'({op_valid, read_weight, write_weight, illegal}), 0);
    chk("t6_rst_op_wa", int'({op, weight_addr}), 0);
    chk("t6_rst_addr", int'(instr_addr), 0);
    tick();
    chk("t6_idle_stays", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
